// File: rtl/motor_ramp_sequencer.sv
// Per-motor level/direction sequencer: slews toward the target, brakes and waits out a dead time on reversal.
// Optional build macro ESTOP_LATCH_EN: leaving HALT also requires an enable_in rising edge.
module motor_ramp_sequencer #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 1,
  parameter int DEAD_TICKS = 50
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] target_level_in,
  input  logic             target_dir_in,
  input  logic             enable_in,
  input  logic             estop_in,
  output logic [WIDTH-1:0] level_out,
  output logic             direction_out,
  output logic             busy_out,
  output logic [2:0]       state_out
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_TICKS);
  localparam logic [WIDTH-1:0]  STEP_U   = WIDTH'(STEP);
  localparam logic signed [WIDTH+1:0] STEP_S = (WIDTH+2)'(STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    BRAKE = 3'd2,
    DEAD  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic [DEAD_W-1:0]  dead_cnt;
  logic               tick;
  logic [WIDTH-1:0]   eff_target;
  logic               dir_change;
  logic               halt_release;

  // One STEP toward goal; the signed gap decides whether this is the final, partial step.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] level,
                                                   input logic [WIDTH-1:0] goal);
    logic signed [WIDTH+1:0] gap;
    gap = $signed({2'b00, goal}) - $signed({2'b00, level});
    if (gap > STEP_S)
      return level + STEP_U;
    else if (gap < -STEP_S)
      return level - STEP_U;
    else
      return goal;
  endfunction

  assign tick       = (tick_cnt == CNT_MAX);
  assign eff_target = enable_in ? target_level_in : '0;
  assign dir_change = (eff_target != '0) && (target_dir_in != direction_out);
  assign state_out  = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CNT_W'(1);
  end

`ifdef ESTOP_LATCH_EN
  // HALT acts as the sticky stop latch; it opens only on a fresh enable edge once estop is gone.
  logic enable_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      enable_q <= 1'b0;
    else
      enable_q <= enable_in;
  end

  assign halt_release = !estop_in && enable_in && !enable_q;
`else
  assign halt_release = !estop_in;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      level_out     <= '0;
      direction_out <= 1'b0;
      busy_out      <= 1'b0;
      dead_cnt      <= '0;
    end else if (estop_in) begin
      state     <= HALT;
      busy_out  <= 1'b1;
      level_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dir_change) begin
            state    <= (level_out != '0) ? BRAKE : DEAD;
            busy_out <= 1'b1;
            dead_cnt <= '0;
          end else if (eff_target != level_out) begin
            state    <= RAMP;
            busy_out <= 1'b1;
          end
        end
        RAMP: begin
          // A reversal swallows any tick in the same cycle.
          if (dir_change)
            state <= BRAKE;
          else if (level_out == eff_target) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (tick)
            level_out <= step_toward(level_out, eff_target);
        end
        BRAKE: begin
          if (level_out == '0) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end else if (tick)
            level_out <= step_toward(level_out, '0);
        end
        DEAD: begin
          level_out <= '0;
          if (dead_cnt == DEAD_MAX) begin
            direction_out <= target_dir_in;
            state         <= IDLE;
            busy_out      <= 1'b0;
          end else if (tick)
            dead_cnt <= dead_cnt + DEAD_W'(1);
        end
        HALT: begin
          level_out <= '0;
          if (halt_release) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
